// File: rtl/tod_slave_cfg_sequencer.sv
// AXI4-Lite master that programs a TodSlave (baud rate, then enable word) and then
// polls its status register, reporting done/error and the last status word.
module tod_slave_cfg_sequencer #(
  parameter logic [15:0] BaudRateAddr_Gen = 16'h0020,
  parameter logic [15:0] ControlAddr_Gen  = 16'h0000,
  parameter logic [15:0] StatusAddr_Gen   = 16'h0004,
  parameter logic [31:0] BaudRate_Gen     = 32'd7,
  parameter logic [31:0] ControlValue_Gen = 32'h0000_0001,
  parameter logic [31:0] PollPeriod_Gen   = 32'd1000,
  parameter logic [31:0] Timeout_Gen      = 32'd256
) (
  input  logic        SysClk_ClkIn,
  input  logic        SysRst_RstIn,
  input  logic        Start_EvtIn,
  output logic        Busy_ValOut,
  output logic        Done_ValOut,
  output logic        Error_ValOut,
  output logic [31:0] Status_DatOut,
  output logic        AxiWriteAddrValid_ValOut,
  input  logic        AxiWriteAddrReady_RdyIn,
  output logic [15:0] AxiWriteAddrAddress_AdrOut,
  output logic [2:0]  AxiWriteAddrProt_DatOut,
  output logic        AxiWriteDataValid_ValOut,
  input  logic        AxiWriteDataReady_RdyIn,
  output logic [31:0] AxiWriteDataData_DatOut,
  output logic [3:0]  AxiWriteDataStrobe_DatOut,
  input  logic        AxiWriteRespValid_ValIn,
  output logic        AxiWriteRespReady_RdyOut,
  input  logic [1:0]  AxiWriteRespResponse_DatIn,
  output logic        AxiReadAddrValid_ValOut,
  input  logic        AxiReadAddrReady_RdyIn,
  output logic [15:0] AxiReadAddrAddress_AdrOut,
  output logic [2:0]  AxiReadAddrProt_DatOut,
  input  logic        AxiReadDataValid_ValIn,
  output logic        AxiReadDataReady_RdyOut,
  input  logic [1:0]  AxiReadDataResponse_DatIn,
  input  logic [31:0] AxiReadDataData_DatIn
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_BAUD, S_WR_CTRL, S_RD_STAT, S_POLL_WAIT, S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic        arvalid_q, arvalid_d, rready_q, rready_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic        done_q, done_d, error_q, error_d;
  logic [15:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [31:0] wdata_q, wdata_d, status_q, status_d;
  logic [31:0] tmo_q, tmo_d, poll_q, poll_d;
  logic        aw_acc, w_acc, launch_baud, launch_ctrl, launch_rd, fail;

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    done_d      = done_q;
    error_d     = error_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    status_d    = status_q;
    tmo_d       = (tmo_q == '1) ? tmo_q : tmo_q + 32'd1;
    poll_d      = (poll_q == '1) ? poll_q : poll_q + 32'd1;
    aw_acc      = aw_done_q | (awvalid_q & AxiWriteAddrReady_RdyIn);
    w_acc       = w_done_q | (wvalid_q & AxiWriteDataReady_RdyIn);
    launch_baud = 1'b0;
    launch_ctrl = 1'b0;
    launch_rd   = 1'b0;
    fail        = 1'b0;

    unique case (state_q)
      S_IDLE: launch_baud = 1'b1;
      S_WR_BAUD, S_WR_CTRL: begin
        // AW and W retire independently; B is only accepted once both are in.
        if (awvalid_q & AxiWriteAddrReady_RdyIn) awvalid_d = 1'b0;
        if (wvalid_q & AxiWriteDataReady_RdyIn)  wvalid_d  = 1'b0;
        aw_done_d = aw_acc;
        w_done_d  = w_acc;
        bready_d  = aw_acc & w_acc;
        if (bready_q & AxiWriteRespValid_ValIn) begin
          bready_d = 1'b0;
          if (AxiWriteRespResponse_DatIn != 2'b00) fail = 1'b1;
          else if (state_q == S_WR_BAUD)           launch_ctrl = 1'b1;
          else                                     launch_rd = 1'b1;
        end else if (tmo_d >= Timeout_Gen) begin
          fail = 1'b1;
        end
      end
      S_RD_STAT: begin
        if (arvalid_q & AxiReadAddrReady_RdyIn) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
        if (rready_q & AxiReadDataValid_ValIn) begin
          rready_d = 1'b0;
          status_d = AxiReadDataData_DatIn;
          if (AxiReadDataResponse_DatIn != 2'b00) begin
            fail = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = S_POLL_WAIT;
            poll_d  = '0;
          end
        end else if (tmo_d >= Timeout_Gen) begin
          fail = 1'b1;
        end
      end
      S_POLL_WAIT: begin
        if (Start_EvtIn) begin
          launch_baud = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
        end else if (poll_d >= PollPeriod_Gen) begin
          launch_rd = 1'b1;
        end
      end
      S_ERROR: begin
        if (Start_EvtIn) begin
          launch_baud = 1'b1;
          error_d     = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (launch_baud | launch_ctrl) begin
      state_d   = launch_baud ? S_WR_BAUD : S_WR_CTRL;
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      bready_d  = 1'b0;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      awaddr_d  = launch_baud ? BaudRateAddr_Gen : ControlAddr_Gen;
      wdata_d   = launch_baud ? BaudRate_Gen : ControlValue_Gen;
      tmo_d     = '0;
    end
    if (launch_rd) begin
      state_d   = S_RD_STAT;
      arvalid_d = 1'b1;
      rready_d  = 1'b0;
      araddr_d  = StatusAddr_Gen;
      tmo_d     = '0;
    end
    if (fail) begin
      state_d   = S_ERROR;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      error_d   = 1'b1;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge SysClk_ClkIn) begin
    if (SysRst_RstIn) begin
      state_q   <= S_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      status_q  <= '0;
      tmo_q     <= '0;
      poll_q    <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      done_q    <= done_d;
      error_q   <= error_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      status_q  <= status_d;
      tmo_q     <= tmo_d;
      poll_q    <= poll_d;
    end
  end

  assign Busy_ValOut                = state_q inside {S_WR_BAUD, S_WR_CTRL, S_RD_STAT};
  assign Done_ValOut                = done_q;
  assign Error_ValOut               = error_q;
  assign Status_DatOut              = status_q;
  assign AxiWriteAddrValid_ValOut   = awvalid_q;
  assign AxiWriteAddrAddress_AdrOut = awaddr_q;
  assign AxiWriteAddrProt_DatOut    = '0;
  assign AxiWriteDataValid_ValOut   = wvalid_q;
  assign AxiWriteDataData_DatOut    = wdata_q;
  assign AxiWriteDataStrobe_DatOut  = '1;
  assign AxiWriteRespReady_RdyOut   = bready_q;
  assign AxiReadAddrValid_ValOut    = arvalid_q;
  assign AxiReadAddrAddress_AdrOut  = araddr_q;
  assign AxiReadAddrProt_DatOut     = '0;
  assign AxiReadDataReady_RdyOut    = rready_q;

endmodule

// File: tb/tb_tod_slave_cfg_sequencer.sv
// Bench: behavioural AXI4-Lite slave with randomised latencies, transaction log
// compared against the expected configuration sequence.
module tb_tod_slave_cfg_sequencer;

  localparam int POLL = 10;
  localparam int TMO  = 40;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
  } tx_t;

  logic        clk, rst, start;
  logic        busy, done, err;
  logic [31:0] status;
  logic        awv, awready, wv, wready, bvalid, bready, arv, arready, rvalid, rready;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  tod_slave_cfg_sequencer #(
    .PollPeriod_Gen(32'd10),
    .Timeout_Gen   (32'd40)
  ) dut (
    .SysClk_ClkIn              (clk),
    .SysRst_RstIn              (rst),
    .Start_EvtIn               (start),
    .Busy_ValOut               (busy),
    .Done_ValOut               (done),
    .Error_ValOut              (err),
    .Status_DatOut             (status),
    .AxiWriteAddrValid_ValOut  (awv),
    .AxiWriteAddrReady_RdyIn   (awready),
    .AxiWriteAddrAddress_AdrOut(awaddr),
    .AxiWriteAddrProt_DatOut   (awprot),
    .AxiWriteDataValid_ValOut  (wv),
    .AxiWriteDataReady_RdyIn   (wready),
    .AxiWriteDataData_DatOut   (wdata),
    .AxiWriteDataStrobe_DatOut (wstrb),
    .AxiWriteRespValid_ValIn   (bvalid),
    .AxiWriteRespReady_RdyOut  (bready),
    .AxiWriteRespResponse_DatIn(bresp),
    .AxiReadAddrValid_ValOut   (arv),
    .AxiReadAddrReady_RdyIn    (arready),
    .AxiReadAddrAddress_AdrOut (araddr),
    .AxiReadAddrProt_DatOut    (arprot),
    .AxiReadDataValid_ValIn    (rvalid),
    .AxiReadDataReady_RdyOut   (rready),
    .AxiReadDataResponse_DatIn (rresp),
    .AxiReadDataData_DatIn     (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  n_chk = 0;
  int  n_err = 0;
  tx_t log_q[$];

  // slave controls: latency < 0 means random 0..3
  int  aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = -1, r_lat = -1;
  bit  err_baud = 0, no_arready = 0, lead_check = 0;
  int  bready_viol = 0;
  int  cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input int fix);
    return (fix >= 0) ? fix : int'($urandom_range(0, 3));
  endfunction

  // Expected k-th transaction after a (re)start: baud write, control write, then status reads.
  function automatic tx_t exp_tx(input int k);
    tx_t t;
    t.wr   = (k < 2);
    t.addr = (k == 0) ? 16'h0020 : (k == 1) ? 16'h0000 : 16'h0004;
    t.data = (k == 0) ? 32'd7 : (k == 1) ? 32'd1 : 32'd0;
    return t;
  endfunction

  task automatic check_run(input string tag, input int n);
    tx_t e;
    check({tag, "_len"}, 64'(log_q.size() >= n), 64'd1);
    for (int i = 0; i < n && i < log_q.size(); i++) begin
      e = exp_tx(i);
      check({tag, "_kind"}, 64'(log_q[i].wr), 64'(e.wr));
      check({tag, "_addr"}, 64'(log_q[i].addr), 64'(e.addr));
      if (e.wr) check({tag, "_data"}, 64'(log_q[i].data), 64'(e.data));
    end
  endtask

  // sel: 0 done, 1 error, 2 AWVALID, 3 ARVALID, 4 not busy
  task automatic wait_for(input int sel, input string tag, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      case (sel)
        0: ok = done;
        1: ok = err;
        2: ok = awv;
        3: ok = arv;
        default: ok = !busy;
      endcase
      if (ok) break;
    end
    check({"wait_", tag}, 64'(ok), 64'd1);
    #1;
  endtask

  task automatic pulse_start(input string tag);
    wait_for(4, {tag, "_idle"}, 200);
    log_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Behavioural AXI4-Lite slave; handshakes of a posedge are resolved at the following negedge.
  initial begin : slave
    logic        p_awv, p_wv, p_bready, p_arv, p_rready;
    logic [15:0] p_awaddr, p_araddr, cur_addr, cur_raddr;
    logic [31:0] p_wdata, cur_data, rdata_next;
    bit          aw_ok, w_ok, r_pend, last_r_valid;
    int          aw_n, w_n, aw_cyc, w_cyc, last_r_cyc;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    tx_t         t;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    p_awv = 0; p_wv = 0; p_bready = 0; p_arv = 0; p_rready = 0;
    p_awaddr = 0; p_araddr = 0; p_wdata = 0; cur_addr = 0; cur_raddr = 0; cur_data = 0;
    rdata_next = 32'hA5;
    aw_ok = 0; w_ok = 0; r_pend = 0; last_r_valid = 0;
    aw_n = 0; w_n = 0; aw_cyc = 0; w_cyc = 0; last_r_cyc = 0;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0;
        aw_ok = 0; w_ok = 0; aw_n = 0; w_n = 0; r_pend = 0; last_r_valid = 0;
      end else begin
        if (p_awv && awready) begin
          awready = 0; aw_ok = 1; aw_n++; cur_addr = p_awaddr; aw_cyc = cyc;
        end
        if (p_wv && wready) begin
          wready = 0; w_ok = 1; w_n++; cur_data = p_wdata; w_cyc = cyc;
        end
        if (p_bready && bvalid) begin
          bvalid = 0;
          t.wr = 1'b1; t.addr = cur_addr; t.data = cur_data;
          log_q.push_back(t);
          check("one_aw", 64'(aw_n), 64'd1);
          check("one_w", 64'(w_n), 64'd1);
          if (lead_check) check("w_lead", 64'(aw_cyc - w_cyc), 64'd3);
          aw_ok = 0; w_ok = 0; aw_n = 0; w_n = 0;
        end
        if (p_arv && arready) begin
          arready = 0; r_pend = 1; cur_raddr = p_araddr;
        end
        if (p_rready && rvalid) begin
          rvalid = 0; r_pend = 0;
          t.wr = 1'b0; t.addr = cur_raddr; t.data = rdata;
          log_q.push_back(t);
          check("status", 64'(status), 64'(rdata));
          check("done_after_read", 64'(done), 64'd1);
          last_r_cyc = cyc; last_r_valid = 1;
          rdata_next++;
        end
        if (bready && !(aw_ok && w_ok)) bready_viol++;

        if (awv && !p_awv) begin
          aw_dly = pick(aw_lat); w_dly = pick(w_lat); b_dly = pick(b_lat);
          last_r_valid = 0;
        end
        if (awv && !awready && !aw_ok) begin
          if (aw_dly == 0) awready = 1; else aw_dly--;
        end
        if (wv && !wready && !w_ok) begin
          if (w_dly == 0) wready = 1; else w_dly--;
        end
        if (aw_ok && w_ok && !bvalid) begin
          if (b_dly == 0) begin
            bvalid = 1;
            bresp  = (err_baud && cur_addr == 16'h0020) ? 2'b10 : 2'b00;
          end else b_dly--;
        end
        if (arv && !p_arv) begin
          ar_dly = pick(ar_lat); r_dly = pick(r_lat);
          if (last_r_valid) check("poll_gap", 64'(cyc - last_r_cyc), 64'(POLL));
        end
        if (arv && !arready && !no_arready) begin
          if (ar_dly == 0) arready = 1; else ar_dly--;
        end
        if (r_pend && !rvalid) begin
          if (r_dly == 0) begin
            rvalid = 1; rdata = rdata_next; rresp = 2'b00;
          end else r_dly--;
        end
      end
      p_awv = awv; p_wv = wv; p_bready = bready; p_arv = arv; p_rready = rready;
      p_awaddr = awaddr; p_araddr = araddr; p_wdata = wdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int n;
    int quiet_n;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctl", 64'({awv, wv, bready, arv, rready, busy, done, err}), 64'd0);
    check("rst_awaddr", 64'(awaddr), 64'd0);
    check("rst_araddr", 64'(araddr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_status", 64'(status), 64'd0);

    // Same-clock AW/W acceptance, BVALID one clock later.
    log_q.delete();
    rst = 1'b0;
    wait_for(0, "a_done", 300);
    check("a_status", 64'(status), 64'hA5);
    check("a_busy_poll", 64'(busy), 64'd0);
    check("a_err", 64'(err), 64'd0);
    check_run("a_seq", 3);
    repeat (40) @(negedge clk);

    // W accepted three clocks ahead of AW.
    aw_lat = 3; w_lat = 0; b_lat = -1; lead_check = 1;
    pulse_start("b");
    check("b_busy", 64'(busy), 64'd1);
    check("b_done_clr", 64'(done), 64'd0);
    wait_for(0, "b_done", 300);
    check_run("b_seq", 3);
    lead_check = 0;
    check("bready_early", 64'(bready_viol), 64'd0);

    // Random latencies, a few polls each.
    aw_lat = -1; w_lat = -1;
    for (int r = 0; r < 3; r++) begin
      pulse_start("c");
      wait_for(0, "c_done", 300);
      check_run("c_seq", 3);
      repeat (50) @(negedge clk);
    end
    check("bready_early2", 64'(bready_viol), 64'd0);

    // SLVERR on the baud write.
    err_baud = 1;
    pulse_start("d");
    wait_for(1, "d_err", 300);
    check("d_done", 64'(done), 64'd0);
    check("d_log_len", 64'(log_q.size()), 64'd1);
    check_run("d_seq", 1);
    quiet_n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      quiet_n += int'(awv | wv | bready | arv | rready);
    end
    check("d_quiet", 64'(quiet_n), 64'd0);
    check("d_err_sticky", 64'(err), 64'd1);
    err_baud = 0;
    pulse_start("d2");
    check("d_err_clr", 64'(err), 64'd0);
    wait_for(0, "d2_done", 300);
    check_run("d2_seq", 3);

    // ARREADY never comes: error exactly TMO clocks after ARVALID rises.
    no_arready = 1;
    pulse_start("e");
    wait_for(3, "e_arv", 300);
    n = 0;
    for (int i = 0; i < TMO + 20; i++) begin
      @(negedge clk);
      n++;
      if (err) break;
    end
    check("e_tmo_clks", 64'(n), 64'(TMO));
    check("e_arv_drop", 64'(arv), 64'd0);
    no_arready = 0;

    // Reset while AWVALID is high.
    pulse_start("f");
    wait_for(2, "f_awv", 50);
    rst = 1'b1;
    @(negedge clk);
    check("f_rst_ctl", 64'({awv, wv, bready, arv, rready, busy, done, err}), 64'd0);
    check("f_rst_status", 64'(status), 64'd0);
    @(negedge clk);
    log_q.delete();
    rst = 1'b0;
    wait_for(0, "f_done", 300);
    check_run("f_seq", 3);

    check("const_prot_strb", 64'({awprot, arprot, wstrb}), 64'h00F);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
